// File: rtl/fifo_sb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_sb_pkg
//  Description : Shared types, error-bit indices and pointer helper for the
//                FIFO scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_sb_pkg;

    // Matching discipline between writes and reads
    typedef enum logic {
        SB_IN_ORDER  = 1'b0,
        SB_ANY_ORDER = 1'b1
    } ordering_e;

    // Bit positions inside the registered error vector
    localparam int ERR_MISM = 0;
    localparam int ERR_OVF  = 1;
    localparam int ERR_UNF  = 2;
    localparam int ERR_FLG  = 3;
    localparam int ERR_NUM  = 4;

    // Advance a circular pointer; depth need not be a power of two
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_scoreboard_model_store.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_sb_store
//  Description : Shadow storage for the scoreboard: DEPTH x DATA_W memory with
//                per-entry valid bits, one write port, one indexed pop, a
//                first-match value search and a first-free-slot search.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_sb_store #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop_en,
    input  logic [IDX_W-1:0]  pop_idx,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    input  logic [DATA_W-1:0] srch_data,
    output logic              srch_hit,
    output logic [IDX_W-1:0]  srch_idx,
    output logic [IDX_W-1:0]  free_idx
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_vld;

    // Entry update: a write to the slot being popped wins, so replace-in-place works
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (pop_en) begin
                r_vld[pop_idx] <= 1'b0;
            end
            if (wr_en) begin
                r_vld[wr_idx] <= 1'b1;
                r_mem[wr_idx] <= wr_data;
            end
        end
    end

    assign rd_data = r_mem[rd_idx];

    // Lowest valid index holding srch_data, and lowest free index
    always_comb begin
        logic w_free_found;
        srch_hit     = 1'b0;
        srch_idx     = '0;
        free_idx     = '0;
        w_free_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!srch_hit && r_vld[i] && (r_mem[i] == srch_data)) begin
                srch_hit = 1'b1;
                srch_idx = IDX_W'(i);
            end
            if (!w_free_found && !r_vld[i]) begin
                w_free_found = 1'b1;
                free_idx     = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_scoreboard_model.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_scoreboard_model
//  Description : Synthesizable FIFO scoreboard. Shadows accepted writes,
//                checks every accepted read (in-order or any-order), checks
//                the DUT full/empty flags and keeps saturating traffic counts.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_scoreboard_model
    import fifo_sb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int ORDERING  = 0,
    parameter int CHECK_FLG = 1,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic                       in_vld,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       out_vld,
    input  logic [DATA_W-1:0]          out_data,
    input  logic                       dut_full,
    input  logic                       dut_empty,
    output logic                       err_mismatch,
    output logic                       err_overflow,
    output logic                       err_underflow,
    output logic                       err_flag,
    output logic                       err_sticky,
    output logic [DATA_W-1:0]          exp_data,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic [CNT_W-1:0]           wr_cnt,
    output logic [CNT_W-1:0]           rd_cnt
);

    localparam int                PTR_W      = $clog2(DEPTH);
    localparam int                PEND_W     = $clog2(DEPTH+1);
    localparam logic [PEND_W-1:0] c_full_lvl = PEND_W'(DEPTH);
    localparam logic [CNT_W-1:0]  c_cnt_max  = '1;
    localparam ordering_e         c_mode     = (ORDERING != 0) ? SB_ANY_ORDER : SB_IN_ORDER;
    localparam bit                c_any      = (c_mode == SB_ANY_ORDER);
    localparam bit                c_chk_flg  = (CHECK_FLG != 0);

    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PEND_W-1:0]  r_pending;
    logic [ERR_NUM-1:0] r_err;
    logic               r_sticky;
    logic [DATA_W-1:0]  r_exp;
    logic [CNT_W-1:0]   r_wr_cnt;
    logic [CNT_W-1:0]   r_rd_cnt;
    logic               r_first;

    logic               w_is_empty;
    logic               w_is_full;
    logic [ERR_NUM-1:0] w_err;
    logic               w_st_wr_en;
    logic [PTR_W-1:0]   w_st_wr_idx;
    logic               w_st_pop_en;
    logic [PTR_W-1:0]   w_st_pop_idx;
    logic [DATA_W-1:0]  w_head_data;
    logic               w_hit;
    logic [PTR_W-1:0]   w_hit_idx;
    logic [PTR_W-1:0]   w_free_idx;
    logic               w_wr_adv;
    logic               w_rd_adv;
    logic [PEND_W-1:0]  w_pend_nxt;
    logic               w_cap;
    logic [DATA_W-1:0]  w_cap_val;

    fifo_sb_store #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (PTR_W)
    ) u_store (
        .clk       (clk),
        .rstN      (rstN),
        .wr_en     (w_st_wr_en),
        .wr_idx    (w_st_wr_idx),
        .wr_data   (in_data),
        .pop_en    (w_st_pop_en),
        .pop_idx   (w_st_pop_idx),
        .rd_idx    (r_rd_ptr),
        .rd_data   (w_head_data),
        .srch_data (out_data),
        .srch_hit  (w_hit),
        .srch_idx  (w_hit_idx),
        .free_idx  (w_free_idx)
    );

    assign w_is_empty = (r_pending == '0);
    assign w_is_full  = (r_pending == c_full_lvl);

    // Event decode: classify the cycle on the pre-edge occupancy and plan store/pop/errors
    always_comb begin
        w_err        = '0;
        w_st_wr_en   = 1'b0;
        w_st_wr_idx  = c_any ? w_free_idx : r_wr_ptr;
        w_st_pop_en  = 1'b0;
        w_st_pop_idx = c_any ? w_hit_idx : r_rd_ptr;
        w_wr_adv     = 1'b0;
        w_rd_adv     = 1'b0;
        w_pend_nxt   = r_pending;
        w_cap        = 1'b0;
        w_cap_val    = w_head_data;

        if (in_vld && !out_vld) begin
            if (w_is_full) begin
                w_err[ERR_OVF] = 1'b1;
            end else begin
                w_st_wr_en = 1'b1;
                w_wr_adv   = 1'b1;
                w_pend_nxt = r_pending + PEND_W'(1);
            end
        end else if (!in_vld && out_vld) begin
            if (w_is_empty) begin
                w_err[ERR_UNF] = 1'b1;
            end else if (!c_any) begin
                // The head is popped even on a mismatch so later reads stay aligned
                w_st_pop_en = 1'b1;
                w_rd_adv    = 1'b1;
                w_pend_nxt  = r_pending - PEND_W'(1);
                if (out_data != w_head_data) begin
                    w_err[ERR_MISM] = 1'b1;
                    w_cap           = 1'b1;
                end
            end else if (w_hit) begin
                w_st_pop_en = 1'b1;
                w_pend_nxt  = r_pending - PEND_W'(1);
            end else begin
                w_err[ERR_MISM] = 1'b1;
            end
        end else if (in_vld && out_vld) begin
            if (w_is_empty) begin
                // Bypass: the write feeds the read directly, nothing is stored
                if (out_data != in_data) begin
                    w_err[ERR_MISM] = 1'b1;
                    w_cap           = !c_any;
                    w_cap_val       = in_data;
                end
            end else if (!c_any) begin
                w_st_pop_en = 1'b1;
                w_rd_adv    = 1'b1;
                w_st_wr_en  = 1'b1;
                w_wr_adv    = 1'b1;
                if (out_data != w_head_data) begin
                    w_err[ERR_MISM] = 1'b1;
                    w_cap           = 1'b1;
                end
            end else if (w_hit) begin
                // Free the matched slot and reuse it for the incoming write
                w_st_pop_en = 1'b1;
                w_st_wr_en  = 1'b1;
                w_st_wr_idx = w_hit_idx;
            end else if (in_data != out_data) begin
                w_err[ERR_MISM] = 1'b1;
                if (!w_is_full) begin
                    w_st_wr_en = 1'b1;
                    w_pend_nxt = r_pending + PEND_W'(1);
                end
            end
        end

        w_err[ERR_FLG] = c_chk_flg && !r_first &&
                         ((dut_full != w_is_full) || (dut_empty != w_is_empty));
    end

    // Pointers, occupancy and the post-reset flag-check mask
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_pending <= '0;
            r_first   <= 1'b1;
        end else begin
            if (w_wr_adv) begin
                r_wr_ptr <= PTR_W'(ptr_inc(32'(r_wr_ptr), DEPTH));
            end
            if (w_rd_adv) begin
                r_rd_ptr <= PTR_W'(ptr_inc(32'(r_rd_ptr), DEPTH));
            end
            r_pending <= w_pend_nxt;
            r_first   <= 1'b0;
        end
    end

    // Registered error pulses, sticky summary and captured expected value
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_err    <= '0;
            r_sticky <= 1'b0;
            r_exp    <= '0;
        end else begin
            r_err    <= w_err;
            r_sticky <= r_sticky | (|w_err);
            if (w_cap) begin
                r_exp <= w_cap_val;
            end
        end
    end

    // Saturating traffic counters, counting erroneous events too
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (in_vld && (r_wr_cnt != c_cnt_max)) begin
                r_wr_cnt <= r_wr_cnt + CNT_W'(1);
            end
            if (out_vld && (r_rd_cnt != c_cnt_max)) begin
                r_rd_cnt <= r_rd_cnt + CNT_W'(1);
            end
        end
    end

    assign err_mismatch  = r_err[ERR_MISM];
    assign err_overflow  = r_err[ERR_OVF];
    assign err_underflow = r_err[ERR_UNF];
    assign err_flag      = r_err[ERR_FLG];
    assign err_sticky    = r_sticky;
    assign exp_data      = r_exp;
    assign pending       = r_pending;
    assign wr_cnt        = r_wr_cnt;
    assign rd_cnt        = r_rd_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo_scoreboard_model.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_scoreboard_model
//  Description : Bench for fifo_scoreboard_model. Two instances (in-order with
//                16-bit counters, any-order with 4-bit counters) share one
//                traffic stream; each is checked against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_scoreboard_model;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst_n;
    logic        in_vld;
    logic [31:0] in_data;
    logic        out_vld;
    logic [31:0] out_data;
    logic        f0_full, f0_empty, f1_full, f1_empty;

    logic        e0_mm, e0_ov, e0_un, e0_fg, e0_st;
    logic [31:0] x0;
    logic [3:0]  p0;
    logic [15:0] wc0, rc0;
    logic        e1_mm, e1_ov, e1_un, e1_fg, e1_st;
    logic [31:0] x1;
    logic [3:0]  p1;
    logic [3:0]  wc1, rc1;

    fifo_scoreboard_model #(.DATA_W(32), .DEPTH(DEPTH), .ORDERING(0), .CHECK_FLG(1), .CNT_W(16)) u_dut0 (
        .clk(clk), .rstN(rst_n), .in_vld(in_vld), .in_data(in_data),
        .out_vld(out_vld), .out_data(out_data), .dut_full(f0_full), .dut_empty(f0_empty),
        .err_mismatch(e0_mm), .err_overflow(e0_ov), .err_underflow(e0_un), .err_flag(e0_fg),
        .err_sticky(e0_st), .exp_data(x0), .pending(p0), .wr_cnt(wc0), .rd_cnt(rc0)
    );

    fifo_scoreboard_model #(.DATA_W(32), .DEPTH(DEPTH), .ORDERING(1), .CHECK_FLG(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rstN(rst_n), .in_vld(in_vld), .in_data(in_data),
        .out_vld(out_vld), .out_data(out_data), .dut_full(f1_full), .dut_empty(f1_empty),
        .err_mismatch(e1_mm), .err_overflow(e1_ov), .err_underflow(e1_un), .err_flag(e1_fg),
        .err_sticky(e1_st), .exp_data(x1), .pending(p1), .wr_cnt(wc1), .rd_cnt(rc1)
    );

    always #5 clk = ~clk;

    // Reference model state: a strict FIFO and a multiset
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    bit          m_mm[2], m_ov[2], m_un[2], m_fg[2], m_st[2], m_first[2];
    int          m_wc[2], m_rc[2];
    logic [31:0] m_exp;
    bit          ovr0;
    int          total, bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_exp = '0;
        for (int d = 0; d < 2; d++) begin
            m_mm[d] = 0; m_ov[d] = 0; m_un[d] = 0; m_fg[d] = 0; m_st[d] = 0;
            m_wc[d] = 0; m_rc[d] = 0; m_first[d] = 1;
        end
    endtask

    task automatic model(input int d, input bit iv, input logic [31:0] id,
                         input bit ov, input logic [31:0] od, input bit fl, input bit em);
        int          p;
        int          idx;
        int          cmax;
        logic [31:0] e;
        p    = (d == 0) ? q0.size() : q1.size();
        cmax = (d == 0) ? 65535 : 15;
        m_mm[d] = 0; m_ov[d] = 0; m_un[d] = 0;
        m_fg[d] = !m_first[d] && ((fl != (p == DEPTH)) || (em != (p == 0)));
        idx = -1;
        if (d == 1) begin
            for (int i = 0; i < q1.size(); i++) begin
                if (idx < 0 && q1[i] == od) idx = i;
            end
        end
        if (iv && !ov) begin
            if (p == DEPTH) m_ov[d] = 1;
            else if (d == 0) q0.push_back(id);
            else q1.push_back(id);
        end else if (ov && !iv) begin
            if (p == 0) m_un[d] = 1;
            else if (d == 0) begin
                e = q0.pop_front();
                if (e != od) begin m_mm[d] = 1; m_exp = e; end
            end else if (idx >= 0) q1.delete(idx);
            else m_mm[d] = 1;
        end else if (iv && ov) begin
            if (p == 0) begin
                if (id != od) begin m_mm[d] = 1; if (d == 0) m_exp = id; end
            end else if (d == 0) begin
                e = q0.pop_front();
                if (e != od) begin m_mm[d] = 1; m_exp = e; end
                q0.push_back(id);
            end else if (idx >= 0) begin
                q1.delete(idx);
                q1.push_back(id);
            end else if (id != od) begin
                m_mm[d] = 1;
                if (p < DEPTH) q1.push_back(id);
            end
        end
        if (iv && m_wc[d] < cmax) m_wc[d]++;
        if (ov && m_rc[d] < cmax) m_rc[d]++;
        m_st[d] = m_st[d] | m_mm[d] | m_ov[d] | m_un[d] | m_fg[d];
        m_first[d] = 0;
    endtask

    task automatic check_all();
        chk("d0_mismatch",  32'(e0_mm), 32'(m_mm[0]));
        chk("d0_overflow",  32'(e0_ov), 32'(m_ov[0]));
        chk("d0_underflow", 32'(e0_un), 32'(m_un[0]));
        chk("d0_flag",      32'(e0_fg), 32'(m_fg[0]));
        chk("d0_sticky",    32'(e0_st), 32'(m_st[0]));
        chk("d0_exp_data",  x0,         m_exp);
        chk("d0_pending",   32'(p0),    32'(q0.size()));
        chk("d0_wr_cnt",    32'(wc0),   32'(m_wc[0]));
        chk("d0_rd_cnt",    32'(rc0),   32'(m_rc[0]));
        chk("d1_mismatch",  32'(e1_mm), 32'(m_mm[1]));
        chk("d1_overflow",  32'(e1_ov), 32'(m_ov[1]));
        chk("d1_underflow", 32'(e1_un), 32'(m_un[1]));
        chk("d1_flag",      32'(e1_fg), 32'(m_fg[1]));
        chk("d1_sticky",    32'(e1_st), 32'(m_st[1]));
        chk("d1_pending",   32'(p1),    32'(q1.size()));
        chk("d1_wr_cnt",    32'(wc1),   32'(m_wc[1]));
        chk("d1_rd_cnt",    32'(rc1),   32'(m_rc[1]));
    endtask

    // One clock of traffic; flags follow the model occupancy unless overridden
    task automatic step(input bit iv, input logic [31:0] id, input bit ov, input logic [31:0] od);
        in_vld = iv; in_data = id; out_vld = ov; out_data = od;
        if (!ovr0) begin
            f0_full  = (q0.size() == DEPTH);
            f0_empty = (q0.size() == 0);
        end
        f1_full  = (q1.size() == DEPTH);
        f1_empty = (q1.size() == 0);
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            model(0, iv, id, ov, od, f0_full, f0_empty);
            model(1, iv, id, ov, od, f1_full, f1_empty);
        end
        #1;
        check_all();
        in_vld = 0; out_vld = 0;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 0;
        for (int i = 0; i < cycles; i++) step(0, 0, 0, 0);
        rst_n = 1;
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] od;
        bit          iv, ov;
        clk = 0; rst_n = 0; in_vld = 0; in_data = 0; out_vld = 0; out_data = 0;
        f0_full = 0; f0_empty = 1; f1_full = 0; f1_empty = 1; ovr0 = 0;
        total = 0; bad = 0;
        model_reset();

        do_reset(2);
        step(0, 0, 0, 0);

        // Fill with 0x11..0x88 then drain in order
        for (int i = 1; i <= 8; i++) begin d = 32'(i * 17); step(1, d, 0, 0); end
        step(0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin d = 32'(i * 17); step(0, 0, 1, d); end
        step(0, 0, 0, 0);

        // In-order mismatch and resynchronisation
        step(1, 32'hA5, 0, 0);
        step(1, 32'h5A, 0, 0);
        step(0, 0, 1, 32'h5A);
        step(0, 0, 1, 32'h5A);
        step(0, 0, 0, 0);

        // Reset mid-traffic, then underflow, then bypass
        do_reset(1);
        for (int i = 0; i < 5; i++) step(1, 32'(100 + i), 0, 0);
        do_reset(1);
        step(0, 0, 1, 32'h1);
        step(1, 32'h33, 1, 32'h33);
        step(0, 0, 0, 0);

        // Overflow on the ninth write; full flag agrees at P=8
        do_reset(1);
        for (int i = 0; i < 9; i++) step(1, 32'(200 + i), 0, 0);
        step(0, 0, 0, 0);
        step(1, 32'h77, 1, 32'(200));
        for (int i = 1; i < 8; i++) step(0, 0, 1, 32'(200 + i));
        step(0, 0, 1, 32'h77);
        step(0, 0, 1, 32'h77);

        // Any-order matching and a value that is not pending
        do_reset(1);
        step(1, 1, 0, 0); step(1, 2, 0, 0); step(1, 3, 0, 0);
        step(0, 0, 1, 3); step(0, 0, 1, 1); step(0, 0, 1, 2);
        step(1, 1, 0, 0);
        step(0, 0, 1, 7);
        step(0, 0, 0, 0);

        // Empty flag held high with one entry pending
        do_reset(1);
        step(1, 32'h9, 0, 0);
        ovr0 = 1; f0_full = 0; f0_empty = 1;
        step(0, 0, 0, 0);
        ovr0 = 0;
        step(0, 0, 0, 0);

        // Randomized traffic with a small data alphabet
        do_reset(1);
        for (int n = 0; n < 400; n++) begin
            iv = ($urandom_range(0, 9) < 5);
            ov = ($urandom_range(0, 9) < 5);
            d  = 32'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) od = 32'($urandom_range(0, 15));
            else if (q0.size() > 0)        od = q0[0];
            else                           od = d;
            step(iv, d, ov, od);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
